fft_r2_dif_unload: RTL

Output unloader for the radix-2 DIF FFT datapath. It captures one complete parallel frame from the last butterfly series stage. That frame arrives in bit-reversed order. The block then streams the frame out one complex sample per beat in natural frequency order, under a valid/ready handshake. It sits between the last butterfly series stage and any serial downstream consumer.

---
 rtl/fft_r2_dif_unload.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/fft_r2_dif_unload.sv
// fft_r2_dif_unload
//
// Output unloader for the radix-2 DIF FFT datapath. It captures one whole
// parallel frame from the last butterfly stage. That frame arrives in
// bit-reversed order. The unloader then streams the frame out one complex
// sample per beat, in natural frequency order, under a valid/ready handshake.
//
// Ports:
//   i_clk, i_rst             single clock, synchronous active-high reset
//   i_sink_valid/o_sink_ready parallel frame handshake
//   i_sink_r/i_sink_i         N signed W-bit words, bit-reversed order
//   o_source_valid/i_source_ready serial beat handshake
//   o_source_r/o_source_i     current sample (registered)
//   o_source_idx              natural-order frequency index k
//   o_source_sop/o_source_eop k == 0 / k == N-1 markers
//
// Build option: define FFT_UNLOAD_DOUBLE_BUF_EN to get two ping-pong frame
// buffers. The next frame is then accepted while the current one streams,
// and frames run back to back with no bubble. Without the macro there is a
// single buffer, and one idle cycle separates consecutive frames.
module fft_r2_dif_unload #(
  parameter int DATA_WIDTH = 16,
  parameter int POW        = 3,
  localparam int W         = DATA_WIDTH + 8 + POW,
  localparam int N         = 2 ** POW
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_sink_valid,
  output logic                o_sink_ready,
  input  logic signed [W-1:0] i_sink_r [N],
  input  logic signed [W-1:0] i_sink_i [N],
  output logic                o_source_valid,
  input  logic                i_source_ready,
  output logic signed [W-1:0] o_source_r,
  output logic signed [W-1:0] o_source_i,
  output logic [POW-1:0]      o_source_idx,
  output logic                o_source_sop,
  output logic                o_source_eop
);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  localparam logic [POW-1:0] K_LAST = {POW{1'b1}};

  // Mirror the bits of a frequency index to find where it sits in the
  // bit-reversed frame buffer.
  function automatic logic [POW-1:0] bitrev(input logic [POW-1:0] k);
    logic [POW-1:0] r;
    r = '0;
    for (int b = 0; b < POW; b++) r[b] = k[POW-1-b];
    return r;
  endfunction

  state_t                r_state;
  logic                  r_src_valid;
  logic signed [W-1:0]   r_src_r;
  logic signed [W-1:0]   r_src_i;
  logic [POW-1:0]        r_src_idx;
  logic                  r_src_sop;
  logic                  r_src_eop;

  logic                  w_accept;
  logic                  w_at_last;
  logic [POW-1:0]        w_next_k;

  assign w_accept  = i_sink_valid && o_sink_ready;
  assign w_at_last = (r_src_idx == K_LAST);
  assign w_next_k  = r_src_idx + POW'(1);

  assign o_source_valid = r_src_valid;
  assign o_source_r     = r_src_r;
  assign o_source_i     = r_src_i;
  assign o_source_idx   = r_src_idx;
  assign o_source_sop   = r_src_sop;
  assign o_source_eop   = r_src_eop;

`ifdef FFT_UNLOAD_DOUBLE_BUF_EN

  logic signed [W-1:0] r_buf_r [2][N];
  logic signed [W-1:0] r_buf_i [2][N];
  logic [1:0]          r_full;
  logic                r_wr_sel;
  logic                r_rd_sel;
  logic                w_other;

  // Frames are written and read in strict alternation. So the write pointer
  // always lands on the free buffer whenever one exists. Reset holds ready
  // low because the full flags are not yet known to be clear.
  assign w_other      = ~r_rd_sel;
  assign o_sink_ready = !i_rst && !r_full[r_wr_sel];

  // Ping-pong controller. Incoming frames go to the write buffer. The read
  // buffer is streamed in natural order. At the last beat, the stream hops
  // straight to the other buffer if a frame is waiting there. That frame
  // may even be arriving on this same edge, so it is read directly from the
  // sink inputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_full      <= '0;
      r_wr_sel    <= 1'b0;
      r_rd_sel    <= 1'b0;
      r_src_valid <= 1'b0;
      r_src_r     <= '0;
      r_src_i     <= '0;
      r_src_idx   <= '0;
      r_src_sop   <= 1'b0;
      r_src_eop   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_buf_r[r_wr_sel] <= i_sink_r;
        r_buf_i[r_wr_sel] <= i_sink_i;
        r_full[r_wr_sel]  <= 1'b1;
        r_wr_sel          <= ~r_wr_sel;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state     <= S_STREAM;
            r_src_valid <= 1'b1;
            r_src_r     <= i_sink_r[0];
            r_src_i     <= i_sink_i[0];
            r_src_idx   <= '0;
            r_src_sop   <= 1'b1;
            r_src_eop   <= 1'b0;
          end
        end
        S_STREAM: begin
          if (i_source_ready) begin
            if (w_at_last) begin
              r_full[r_rd_sel] <= 1'b0;
              r_rd_sel         <= w_other;
              r_src_idx        <= '0;
              r_src_eop        <= 1'b0;
              if (r_full[w_other]) begin
                r_src_r   <= r_buf_r[w_other][0];
                r_src_i   <= r_buf_i[w_other][0];
                r_src_sop <= 1'b1;
              end else if (w_accept) begin
                r_src_r   <= i_sink_r[0];
                r_src_i   <= i_sink_i[0];
                r_src_sop <= 1'b1;
              end else begin
                r_state     <= S_IDLE;
                r_src_valid <= 1'b0;
                r_src_r     <= '0;
                r_src_i     <= '0;
                r_src_sop   <= 1'b0;
              end
            end else begin
              r_src_idx <= w_next_k;
              r_src_r   <= r_buf_r[r_rd_sel][bitrev(w_next_k)];
              r_src_i   <= r_buf_i[r_rd_sel][bitrev(w_next_k)];
              r_src_sop <= 1'b0;
              r_src_eop <= (w_next_k == K_LAST);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`else

  logic signed [W-1:0] r_buf_r [N];
  logic signed [W-1:0] r_buf_i [N];

  // With one buffer, a new frame can only land once the previous frame has
  // fully drained. So ready is simply "sitting in IDLE and not in reset".
  assign o_sink_ready = !i_rst && (r_state == S_IDLE);

  // Single-buffer controller. Beat 0 is driven straight from the sink inputs
  // on the accept edge. This makes k=0 visible in the very next cycle, and
  // bitrev(0) is 0, so that is the right word. Later beats read the latched
  // buffer. Leaving the stream clears the data outputs back to zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_src_valid <= 1'b0;
      r_src_r     <= '0;
      r_src_i     <= '0;
      r_src_idx   <= '0;
      r_src_sop   <= 1'b0;
      r_src_eop   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_buf_r     <= i_sink_r;
            r_buf_i     <= i_sink_i;
            r_state     <= S_STREAM;
            r_src_valid <= 1'b1;
            r_src_r     <= i_sink_r[0];
            r_src_i     <= i_sink_i[0];
            r_src_idx   <= '0;
            r_src_sop   <= 1'b1;
            r_src_eop   <= 1'b0;
          end
        end
        S_STREAM: begin
          if (i_source_ready) begin
            if (w_at_last) begin
              r_state     <= S_IDLE;
              r_src_valid <= 1'b0;
              r_src_r     <= '0;
              r_src_i     <= '0;
              r_src_idx   <= '0;
              r_src_sop   <= 1'b0;
              r_src_eop   <= 1'b0;
            end else begin
              r_src_idx <= w_next_k;
              r_src_r   <= r_buf_r[bitrev(w_next_k)];
              r_src_i   <= r_buf_i[bitrev(w_next_k)];
              r_src_sop <= 1'b0;
              r_src_eop <= (w_next_k == K_LAST);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`endif

endmodule
